// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size codes and LSU controller states.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WRITE = 2'd2
  } lsu_state_e;

  function automatic logic ldst_size_legal(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_H) || (size == LDST_W) ||
           (size == LDST_BU) || (size == LDST_HU);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte/half lane logic: load extraction with extension and
// read-modify-write merge of a sub-word store into the fetched word.
module lsu_lane
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  input  logic [15:0]       wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [4:0]        sh;
  logic [DATA_W-1:0] shifted;
  logic              is_half;

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
    return DATA_W'(b);
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
    return DATA_W'(h);
  endfunction

  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] word,
                                                   input logic [DATA_W-1:0] mask,
                                                   input logic [DATA_W-1:0] val,
                                                   input logic [4:0]        amt);
    return (word & ~(mask << amt)) | ((val & mask) << amt);
  endfunction

  assign is_half = (size == LDST_H) || (size == LDST_HU);
  assign sh      = is_half ? {addr_lo[1], 4'b0000} : {addr_lo, 3'b000};
  assign shifted = rdata >> sh;

  always_comb begin
    load_data  = shifted;
    merge_data = rdata;
    unique case (size)
      LDST_B: begin
        load_data  = sext8(shifted[7:0]);
        merge_data = merge_lane(rdata, DATA_W'(8'hFF), DATA_W'(wdata), sh);
      end
      LDST_BU: begin
        load_data  = DATA_W'(shifted[7:0]);
        merge_data = merge_lane(rdata, DATA_W'(8'hFF), DATA_W'(wdata), sh);
      end
      LDST_H: begin
        load_data  = sext16(shifted[15:0]);
        merge_data = merge_lane(rdata, DATA_W'(16'hFFFF), DATA_W'(wdata), sh);
      end
      LDST_HU: begin
        load_data  = DATA_W'(shifted[15:0]);
        merge_data = merge_lane(rdata, DATA_W'(16'hFFFF), DATA_W'(wdata), sh);
      end
      default: begin
        load_data  = shifted;
        merge_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: single-port word memory, sub-word loads
// with extension and sub-word stores via read-modify-write.
module lsu_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [31:0]       core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  lsu_state_e        state_q;
  logic [31:0]       addr_q;
  logic [2:0]        size_q;
  logic              we_q;
  logic [15:0]       wd_q;
  logic              req_err;
  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_merge;

  function automatic logic access_bad(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = !ldst_size_legal(size);
    if ((size == LDST_H || size == LDST_HU) && addr_lo[0]) bad = 1'b1;
    if (size == LDST_W && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  assign req_err = access_bad(core_size_i, core_addr_i[1:0]);

  // Lane logic only ever sees the captured request; the core's live inputs
  // are used solely in the IDLE cycle.
  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (mem_rd_i),
    .wdata      (wd_q),
    .load_data  (lane_load),
    .merge_data (lane_merge)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (core_req_i) begin
            addr_q <= core_addr_i;
            size_q <= core_size_i;
            we_q   <= core_we_i;
            wd_q   <= core_wd_i[15:0];
            if (!req_err) begin
              if (!core_we_i)                state_q <= LOAD_WAIT;
              else if (core_size_i != LDST_W) state_q <= RMW_WRITE;
            end
          end
        end
        LOAD_WAIT: state_q <= IDLE;
        RMW_WRITE: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so an aborted read-modify-write never writes.
  always_comb begin
    core_rd_o    = '0;
    core_stall_o = 1'b0;
    err_o        = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wd_o     = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (core_req_i) begin
            if (req_err) begin
              err_o = 1'b1;
            end else begin
              mem_req_o  = 1'b1;
              mem_addr_o = {core_addr_i[31:2], 2'b00};
              if (core_we_i && core_size_i == LDST_W) begin
                mem_we_o = 1'b1;
                mem_wd_o = core_wd_i;
              end else begin
                core_stall_o = 1'b1;
              end
            end
          end
        end
        LOAD_WAIT: core_rd_o = lane_load;
        RMW_WRITE: begin
          mem_req_o  = 1'b1;
          mem_we_o   = we_q;
          mem_addr_o = {addr_q[31:2], 2'b00};
          mem_wd_o   = lane_merge;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 clk_i  in  1  clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 core_req_i  in  1  core requests a load or store; held with all core_* inputs while core_stall_o=1.
REQ-005 core_we_i  in  1  1=store, 0=load.
REQ-006 core_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5; other codes are illegal.
REQ-007 core_addr_i  in  32  byte address.
REQ-008 core_wd_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 core_rd_o  out  32  load result, extended; valid only in the cycle the load completes, else 0.
REQ-010 core_stall_o  out  1  request not yet complete; the core holds its inputs.
REQ-011 err_o  out  1  one-cycle pulse on a misaligned access or illegal size.
REQ-012 mem_req_o, mem_we_o  out  1 each  data-memory request/write enable; memory performs a read XOR a write per request.
REQ-013 mem_addr_o  out  32  {addr[31:2],2'b00}.
REQ-014 mem_wd_o  out  32  full-word write data.
REQ-015 mem_rd_i  in  32  memory read data: registered, valid the cycle after a read request, held until the next read.

Function
REQ-016 States SHALL be IDLE, LOAD_WAIT and RMW_WRITE.
REQ-017 In IDLE with core_req_i=1, addr, size, we and wd SHALL be captured into registers; later states use only the captured copies.
REQ-018 Error check: H/HU with addr[0]=1, W with addr[1:0]!=0, or illegal size -> err_o=1, no memory request, stall=0, stay IDLE.
REQ-019 Load (IDLE): mem_req_o=1, mem_we_o=0, stall=1 -> LOAD_WAIT.
REQ-020 LOAD_WAIT: mem_req_o=0, stall=0, core_rd_o = lane of mem_rd_i extended per captured size, then -> IDLE; load latency is 2 cycles.
REQ-021 Lane selection: byte lane = addr[1:0]; half lane = addr[1]. B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
REQ-022 Word store (IDLE): mem_req_o=1, mem_we_o=1, mem_wd_o=core_wd_i, stall=0; completes in 1 cycle, stays IDLE.
REQ-023 Sub-word store (IDLE): mem_req_o=1, mem_we_o=0 (read), stall=1 -> RMW_WRITE.
REQ-024 RMW_WRITE: mem_req_o=1, mem_we_o=1, mem_wd_o = mem_rd_i with the selected byte/half replaced by captured wd[7:0]/[15:0], stall=0 -> IDLE.
REQ-025 If core_req_i drops in LOAD_WAIT or RMW_WRITE, the transaction SHALL still complete.
REQ-026 A new request presented in the cycle after completion SHALL be accepted in IDLE with no bubble.
REQ-027 In IDLE with core_req_i=0, all outputs SHALL be 0.

Reset
REQ-028 rst_i=1 SHALL force state to IDLE and clear the captured registers; reset takes priority over any in-flight transaction.
REQ-029 During and after reset, core_rd_o, core_stall_o, err_o, mem_req_o, mem_we_o, mem_addr_o and mem_wd_o SHALL all be 0.
REQ-030 An RMW aborted by reset SHALL NOT issue its write.

Structure
REQ-031 The LDST_* size constants and the state enum SHALL live in the shared riscv_pkg.
REQ-032 One combinational sub-module, lsu_lane, SHALL perform lane extraction/extension and store-lane merge; the FSM stays in lsu_mem_ctrl.

Verification (bench uses a 4096-word, 1-cycle-read memory model)
REQ-033 Word 0x100 = 0x80FF7F01; LB @0x101 -> core_rd_o=0x0000007F; LB @0x102 -> 0xFFFFFFFF; LBU @0x103 -> 0x00000080; each with stall high exactly 1 cycle.
REQ-034 Same word; LH @0x102 -> 0xFFFF80FF; LHU @0x102 -> 0x000080FF; LW @0x100 -> 0x80FF7F01.
REQ-035 Word 0x200 = 0x11223344; SB 0xAA @0x201 -> word reads 0x1122AA44; SH 0xBEEF @0x202 -> 0xBEEFAA44; each store takes 2 cycles with exactly one write request.
REQ-036 SW 0xDEADBEEF @0x300: single cycle, stall never asserted; next-cycle LW @0x300 returns 0xDEADBEEF.
REQ-037 LW @0x302, SH @0x301 and size=3: err_o pulses for 1 cycle each, mem_req_o stays 0, memory unchanged.
REQ-038 Assert rst_i in RMW_WRITE of SB @0x200: no write occurs, word unchanged, all outputs 0; first request after reset is served normally.
